riscv_ifetch: RTL and testbench

Instruction fetch stage with a prefetch queue, sitting directly upstream of the RISC-V decode/execute datapath. It issues word-aligned requests to instruction memory over a request/grant + in-order response bus and buffers returned words with their PCs in a DEPTH-entry FIFO. It presents them to the core over a valid/ready handshake. Taken branches and jumps (e.g. `blt`, `bne`) arrive as a redirect: the queue is flushed, in-flight responses are discarded, and fetch restarts at the target.

---
 rtl/riscv_ifetch.sv | 110 +++++++++++
 tb/tb_riscv_ifetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ifetch.sv
// riscv_ifetch: instruction fetch stage with a DEPTH-entry prefetch queue.
//
// Issues word-aligned requests to instruction memory (request/grant, in-order
// responses), buffers returned words with their PCs, and hands them to the
// core over a valid/ready handshake. A redirect flushes the queue, marks all
// in-flight requests for discard and restarts fetch at the target.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   imem_req/imem_addr/imem_gnt   fetch request channel
//   imem_rvalid/imem_rdata        in-order response channel
//   instr_valid/instr/instr_pc    queue head to the core
//   instr_ready                   core consumes the head
//   redirect/redirect_pc          taken branch/jump, flush and refetch
module riscv_ifetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C1  = CW'(1);
  localparam logic [AW-1:0] P1  = AW'(1);
  localparam logic [CW+1:0] CAP = (CW+2)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t        q_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ, outst, disc;
  logic [31:0]   fetch_pc;

  logic [CW+1:0] credit_used;
  logic          grant, push, drop, pop;
  logic [31:0]   resp_pc;
  entry_t        head;
  logic          redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  // Every queue slot is reserved at request time, so a live response always
  // has room and the queue can never overflow.
  assign credit_used = (CW+2)'(occ) + (CW+2)'(outst) + (CW+2)'(disc);
  assign imem_req    = !rst && !redirect && (credit_used < CAP);
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;

  assign drop        = imem_rvalid && (disc != '0);
  assign push        = imem_rvalid && (disc == '0) && !redirect;
  assign instr_valid = (occ != '0);
  assign pop         = instr_valid && instr_ready && !redirect;

  // Live requests since the last redirect are sequential, so the oldest one
  // sits outst words behind the next fetch address.
  assign resp_pc = fetch_pc - (32'(outst) << 2);

  assign head     = q_mem[rd_ptr];
  assign instr    = instr_valid ? head.word : '0;
  assign instr_pc = instr_valid ? head.pc   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      occ      <= '0;
      outst    <= '0;
      disc     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      outst    <= '0;
      // No grant can happen here (imem_req is low). A response arriving now
      // is dropped whether it was live or already doomed, and it retires one
      // of the requests being folded into disc.
      disc     <= disc + outst - (imem_rvalid ? C1 : '0);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (push)  wr_ptr   <= wr_ptr + P1;
      if (pop)   rd_ptr   <= rd_ptr + P1;
      occ   <= occ   + (push  ? C1 : '0) - (pop  ? C1 : '0);
      outst <= outst + (grant ? C1 : '0) - (push ? C1 : '0);
      disc  <= disc  - (drop  ? C1 : '0);
    end
  end

  // Storage needs no reset: entries are only visible while occ covers them.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {resp_pc, imem_rdata};
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Testbench for riscv_ifetch: memory model with configurable latency, a
// scoreboard of expected PCs popped whenever the core consumes an instruction,
// and one task per scenario.
module tb_riscv_ifetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, instr_pc, redirect_pc;

  int total = 0;
  int bad   = 0;
  int pop_cnt = 0;
  int gnt_cnt = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  riscv_ifetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ ~a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle observer: records grants for the memory model and checks every
  // instruction the core consumes against the scoreboard.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && imem_req === 1'b1 && imem_gnt) begin
        total++;
        if (imem_addr[1:0] !== 2'b00) begin
          bad++; $display("FAIL addr_align: got %h want low bits 00", imem_addr);
        end
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + mem_lat);
        gnt_cnt++;
      end
      if (redirect) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++; $display("FAIL req_in_redirect: got %b want 0", imem_req);
        end
      end
      if (instr_valid !== 1'b1) begin
        total++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
          bad++; $display("FAIL idle_zero: got instr %h pc %h want 0 0", instr, instr_pc);
        end
      end
      if (!rst && instr_valid === 1'b1 && instr_ready && !redirect) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL pop_unexpected: got pc %h want none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr_pc !== e || instr !== mem_word(e)) begin
            bad++;
            $display("FAIL pop_data: got pc %h word %h want pc %h word %h",
                     instr_pc, instr, e, mem_word(e));
          end
        end
        pop_cnt++;
      end
    end
  endtask

  // In-order responder: a grant seen in cycle k is answered in cycle k+lat.
  task automatic mem_drive();
    forever begin
      step();
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0BAD0BAD;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0BAD0BAD;
      end
    end
  endtask

  task automatic do_reset(input logic rdy, input int lat);
    rst = 1'b1;
    redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
    instr_ready = rdy; mem_lat = lat;
    exp_q.delete();
    gnt_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_seq_fetch();
    int base;
    base = pop_cnt;
    do_reset(1'b1, 1);
    for (int i = 0; i < 12; i++) exp_q.push_back(RESET_PC + 32'(i * 4));
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL seq_first_req: got %b %h want 1 %h", imem_req, imem_addr, RESET_PC); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_valid_c0: got %b want 0", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_valid_c1: got %b want 0", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
      bad++; $display("FAIL seq_first_instr: got %b %h want 1 %h", instr_valid, instr_pc, RESET_PC); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL seq_throughput: got %b want 1 at %0d", instr_valid, i); end
    end
    for (int i = 0; i < 50 && pop_cnt < base + 12; i++) step();
    instr_ready = 1'b0;
    total++; if (pop_cnt != base + 12) begin bad++; $display("FAIL seq_drain: got %0d want %0d", pop_cnt - base, 12); end
  endtask

  task automatic test_backpressure();
    int base;
    base = pop_cnt;
    do_reset(1'b0, 1);
    repeat (10) @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
    total++; if (gnt_cnt != DEPTH) begin bad++; $display("FAIL bp_grants: got %0d want %0d", gnt_cnt, DEPTH); end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL bp_head: got %b %h want 1 0", instr_valid, instr_pc); end
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    step();
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && pop_cnt < base + 5; i++) step();
    instr_ready = 1'b0;
    total++; if (pop_cnt != base + 5) begin bad++; $display("FAIL bp_drain: got %0d want 5", pop_cnt - base); end
  endtask

  task automatic test_branch();
    int base;
    base = pop_cnt;
    do_reset(1'b1, 1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd16);
    exp_q.push_back(32'd20); exp_q.push_back(32'd0);
    for (int i = 0; i < 20 && pop_cnt < base + 1; i++) step();
    redirect = 1'b1; redirect_pc = 32'd16;
    step();
    redirect = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'd16) begin
      bad++; $display("FAIL br_redir1: got %b %h want 0 10", instr_valid, imem_addr); end
    for (int i = 0; i < 20 && pop_cnt < base + 3; i++) step();
    redirect = 1'b1; redirect_pc = 32'd0;
    step();
    redirect = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'd0) begin
      bad++; $display("FAIL br_redir2: got %b %h want 0 0", instr_valid, imem_addr); end
    for (int i = 0; i < 20 && pop_cnt < base + 4; i++) step();
    instr_ready = 1'b0;
    total++; if (pop_cnt != base + 4) begin bad++; $display("FAIL br_drain: got %0d want 4", pop_cnt - base); end
  endtask

  task automatic test_redirect_inflight();
    int base;
    base = pop_cnt;
    do_reset(1'b1, 3);
    exp_q.push_back(32'h40); exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    step();
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL inflight_restart: got %b %b %h want 0 1 40", instr_valid, imem_req, imem_addr); end
    for (int i = 0; i < 60 && pop_cnt < base + 3; i++) step();
    instr_ready = 1'b0;
    total++; if (pop_cnt != base + 3) begin bad++; $display("FAIL inflight_drain: got %0d want 3", pop_cnt - base); end
  endtask

  task automatic test_same_cycle();
    int base;
    base = pop_cnt;
    do_reset(1'b1, 1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd4);
    for (int i = 0; i < 20 && pop_cnt < base + 2; i++) step();
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'd8) begin
      bad++; $display("FAIL same_head: got %b %h want 1 8", instr_valid, instr_pc); end
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    step();
    redirect = 1'b0;
    @(negedge clk);
    total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h100) begin
      bad++; $display("FAIL same_after: got %b %h want 0 100", instr_valid, imem_addr); end
    for (int i = 0; i < 30 && pop_cnt < base + 4; i++) step();
    instr_ready = 1'b0;
    total++; if (pop_cnt != base + 4) begin bad++; $display("FAIL same_drain: got %0d want 4", pop_cnt - base); end
  endtask

  task automatic test_async_reset();
    int base;
    do_reset(1'b0, 1);
    repeat (5) @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL ar_before: got %b %h want 1 0", instr_valid, instr_pc); end
    #2 rst = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin
      bad++; $display("FAIL ar_valid: got %b %h want 0 0", instr_valid, instr); end
    total++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL ar_req: got %b %h want 0 %h", imem_req, imem_addr, RESET_PC); end
    base = pop_cnt;
    do_reset(1'b1, 1);
    exp_q.push_back(RESET_PC);
    for (int i = 0; i < 20 && pop_cnt < base + 1; i++) step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h4);
    step();
    redirect = 1'b0;
    @(negedge clk);
    total++; if (imem_addr !== 32'hFFFF_FFF8) begin
      bad++; $display("FAIL ar_wrap_addr: got %h want fffffff8", imem_addr); end
    for (int i = 0; i < 30 && pop_cnt < base + 5; i++) step();
    instr_ready = 1'b0;
    total++; if (pop_cnt != base + 5) begin bad++; $display("FAIL ar_wrap_drain: got %0d want 5", pop_cnt - base); end
  endtask

  initial begin
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1 rst = 1'b1;
    fork
      monitor();
      mem_drive();
    join_none
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_branch();
    test_redirect_inflight();
    test_same_cycle();
    test_async_reset();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
